sync_fifo_param: RTL

Parametrised synchronous FIFO, the next generation of the team's 8x8 FIFO. Width and depth are generic (any depth ≥ 2, not only powers of two). Adds an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, defined simultaneous read/write behaviour at full and empty, and sticky overflow/underflow error flags in place of simulation-only messages. It sits between any producer/consumer pair in one clock domain.

---
 rtl/sync_fifo_param.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with count, thresholds, flush and sticky errors
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             write,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_acc, wr_acc;

  // Pointers wrap by explicit compare so any depth works, not just powers of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // A read frees a slot in the same edge, so a write alongside a read is accepted even when full.
  assign rd_acc = read & (count_q != '0);
  assign wr_acc = write & ((count_q != DEPTH_C) | rd_acc);

  // Next-state: flush wins over read/write and leaves data_out untouched.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = next_ptr(wr_ptr_q);
      end
      if (rd_acc) begin
        rd_ptr_d     = next_ptr(rd_ptr_q);
        data_out_d   = mem[rd_ptr_q];
        data_valid_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (write && !wr_acc) overflow_d  = 1'b1;
      if (read && !rd_acc)  underflow_d = 1'b1;
    end
  end

  // Control and output registers; reset takes effect without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage array is not reset; it is only read when count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

endmodule
